// File: rtl/divide_by3_fsm_pkg.sv
// Shared constants and the successor rule for the divide-by-N tick generator.
// Any out-of-range state wraps straight back to S0 so the counter self-recovers.
package divide_fsm_pkg;

   localparam int DIV_MIN = 2;
   localparam int DIV_MAX = 16;

   // Successor of a state index for a divider of ratio div, including illegal codes
   function automatic int unsigned state_next(input int unsigned state, input int unsigned div);
      int unsigned result;
      if (state >= div - 1) begin
         result = 0;
      end else begin
         result = state + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/divide_by3_fsm_if.sv
// Tick output bundle of the divider: the master drives y, consumers take the slave view.
interface divide_by3_fsm_if;

   logic y;

   modport master (output y);
   modport slave  (input  y);

endinterface

// File: rtl/divide_by3_fsm.sv
// Free-running Moore divider: y is high in S0 only, giving one tick every DIV clocks.
// The state register clears asynchronously to S0 while reset is low.
module divide_by3_fsm
   import divide_fsm_pkg::*;
#(
   parameter int DIV = 3
) (
   input  logic              clk,
   input  logic              reset,
   divide_by3_fsm_if.master  out_if
);

   localparam int SW = $clog2(DIV);
   localparam logic [SW-1:0] S0 = '0;

   if (DIV < DIV_MIN || DIV > DIV_MAX) begin : gDivRange
      $error("divide_by3_fsm: DIV must lie in 2..16");
   end

   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S0;
      state_d = SW'(state_next(32'(state_q), DIV));
   end

   // Decoded from the register alone so the tick cannot glitch
   assign out_if.y = (state_q == S0);

endmodule

// File: tb/tb_divide_by3_fsm.sv
// Bench for divide_by3_fsm at DIV=3, 2 and 5: pattern table, async reset, illegal-state
// recovery, duty counts and random reset pulses against a modulo-count reference.
module tb_divide_by3_fsm;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   divide_by3_fsm_if if3 ();
   divide_by3_fsm_if if2 ();
   divide_by3_fsm_if if5 ();

   divide_by3_fsm #(.DIV(3)) dut3 (.clk(clk), .reset(reset), .out_if(if3.master));
   divide_by3_fsm #(.DIV(2)) dut2 (.clk(clk), .reset(reset), .out_if(if2.master));
   divide_by3_fsm #(.DIV(5)) dut5 (.clk(clk), .reset(reset), .out_if(if5.master));

   int compared   = 0;
   int mismatched = 0;

   // Reference: clocks elapsed since reset, modulo the ratio; a tick whenever it is zero
   int ph3 = 0;
   int ph2 = 0;
   int ph5 = 0;
   bit illegal3 = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ph3 = 0;
         ph2 = 0;
         ph5 = 0;
         illegal3 = 1'b0;
      end else begin
         ph3 = illegal3 ? 0 : (ph3 + 1) % 3;
         illegal3 = 1'b0;
         ph2 = (ph2 + 1) % 2;
         ph5 = (ph5 + 1) % 5;
      end
   end

   typedef struct {
      logic y3;
      logic y2;
      logic y5;
   } vec_t;

   vec_t vecs[12];

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, " y3"}, int'(if3.y), (illegal3 ? 0 : int'(ph3 == 0)));
      checkOutput({tag, " y2"}, int'(if2.y), int'(ph2 == 0));
      checkOutput({tag, " y5"}, int'(if5.y), int'(ph5 == 0));
   endtask

   task automatic applyStimulus(input logic r);
      reset = r;
   endtask

   task automatic nextSample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int highs3;
      int highs5;
      int consec;
      int prev3;
      int hold;

      for (int i = 0; i < 12; i++) begin
         vecs[i].y3 = (i % 3 == 0);
         vecs[i].y2 = (i % 2 == 0);
         vecs[i].y5 = (i % 5 == 0);
      end

      // Reset hold across two edges
      #1 applyStimulus(1'b0);
      #1 checkAll("reset");
      checkOutput("reset state3", int'(dut3.state_q), 0);
      nextSample();
      checkAll("reset e1");
      nextSample();
      checkAll("reset e2");
      checkOutput("reset state3 e2", int'(dut3.state_q), 0);

      // Free run against the fixed pattern table
      @(negedge clk);
      applyStimulus(1'b1);
      #1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) nextSample();
         checkOutput($sformatf("table[%0d] y3", i), int'(if3.y), int'(vecs[i].y3));
         checkOutput($sformatf("table[%0d] y2", i), int'(if2.y), int'(vecs[i].y2));
         checkOutput($sformatf("table[%0d] y5", i), int'(if5.y), int'(vecs[i].y5));
      end

      // DIV=3 sits in S2 here; assert reset mid-cycle and expect y high before any edge
      checkOutput("pre midrst y3", int'(if3.y), 0);
      #2 applyStimulus(1'b0);
      #1 checkOutput("midrst y3 async", int'(if3.y), 1);
      checkAll("midrst");
      @(negedge clk);
      applyStimulus(1'b1);
      #1 checkAll("midrst release");
      nextSample();
      checkOutput("midrst edge1 y3", int'(if3.y), 0);
      checkAll("midrst edge1");
      nextSample();
      checkAll("midrst edge2");
      nextSample();
      checkOutput("midrst edge3 y3", int'(if3.y), 1);
      checkAll("midrst edge3");

      // Illegal code 2'b11 must decode to y=0 and recover to S0 on the next edge
      @(negedge clk);
      force dut3.state_q = 2'b11;
      illegal3 = 1'b1;
      #1 checkOutput("illegal y3", int'(if3.y), 0);
      release dut3.state_q;
      nextSample();
      checkOutput("recover state3", int'(dut3.state_q), 0);
      checkOutput("recover y3", int'(if3.y), 1);
      checkAll("recover");

      // Duty over 300 samples from a fresh release
      @(negedge clk);
      applyStimulus(1'b0);
      @(negedge clk);
      applyStimulus(1'b1);
      #1;
      highs3 = 0;
      highs5 = 0;
      consec = 0;
      prev3  = 0;
      for (int i = 0; i < 300; i++) begin
         if (i > 0) nextSample();
         checkAll("duty");
         if (if3.y) highs3++;
         if (if3.y && prev3 == 1) consec++;
         prev3 = int'(if3.y);
         if (i < 50 && if5.y) highs5++;
      end
      checkOutput("duty highs3 of 300", highs3, 100);
      checkOutput("duty consecutive highs3", consec, 0);
      checkOutput("div5 highs of 50", highs5, 10);

      // Random run lengths interrupted by mid-cycle reset pulses
      for (int k = 0; k < 20; k++) begin
         repeat ($urandom_range(1, 10)) begin
            nextSample();
            checkAll("rand run");
         end
         #($urandom_range(1, 7)) applyStimulus(1'b0);
         #1 checkAll("rand rst");
         hold = $urandom_range(0, 2);
         repeat (hold) begin
            nextSample();
            checkAll("rand hold");
         end
         @(negedge clk);
         applyStimulus(1'b1);
         #1 checkAll("rand release");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
